// File: rtl/bcd_serial_add_ctrl_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the serial packed-BCD adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BCD_W    = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

endpackage

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// ============================================================================
// Module      : bcd_digit_add
// Description : Combinational one-digit BCD adder slice with decimal correction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] digit,
  output logic             cout,
  output logic             invalid
);

  localparam logic [BCD_W:0]   C_MAX_W  = BCD_MAX[BCD_W:0];
  localparam logic [BCD_W:0]   C_CORR_W = BCD_CORR[BCD_W:0];
  localparam logic [BCD_W-1:0] C_MAX_D  = BCD_MAX[BCD_W-1:0];

  logic [BCD_W:0] w_sum;
  logic [BCD_W:0] w_corr;

  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    w_corr = w_sum + C_CORR_W;
    if (w_sum > C_MAX_W) begin
      digit = w_corr[BCD_W-1:0];
      cout  = 1'b1;
    end else begin
      digit = w_sum[BCD_W-1:0];
      cout  = 1'b0;
    end
    invalid = (a > C_MAX_D) || (b > C_MAX_D);
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
// Module      : bcd_serial_add_ctrl
// Description : Multi-digit packed-BCD adder, one digit per clock, LSD first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BCD_W*DIGITS-1:0]   a,
  input  logic [BCD_W*DIGITS-1:0]   b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   sum,
  output logic                      cout,
  output logic                      err
);

  localparam int              IW     = $clog2(DIGITS);
  localparam int              W      = BCD_W * DIGITS;
  localparam logic [IW-1:0]   C_LAST = IW'(DIGITS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic [BCD_W-1:0] w_dig_a;
  logic [BCD_W-1:0] w_dig_b;
  logic [BCD_W-1:0] w_dig_s;
  logic             w_dig_c;
  logic             w_dig_inv;

  assign w_dig_a = a_q[int'(idx_q)*BCD_W +: BCD_W];
  assign w_dig_b = b_q[int'(idx_q)*BCD_W +: BCD_W];

  bcd_digit_add u_slice (
    .a       (w_dig_a),
    .b       (w_dig_b),
    .cin     (carry_q),
    .digit   (w_dig_s),
    .cout    (w_dig_c),
    .invalid (w_dig_inv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        // Result digits land in place so sum never needs shifting.
        sum_d[int'(idx_q)*BCD_W +: BCD_W] = w_dig_s;
        carry_d = w_dig_c;
        err_d   = err_q | w_dig_inv;
        if (idx_q == C_LAST) begin
          cout_d  = w_dig_c;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_bcd_serial_add_ctrl
// Description : Randomized self-checking bench against a decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Valid operands: true decimal addition. Any non-BCD digit: per-digit rule.
  function automatic void model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                input logic c, output logic [W-1:0] s,
                                output logic co, output logic e);
    longint va = 0, vb = 0, tot, lim = 1;
    bit     ok = 1;
    int     da, db, t, cy;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(xa[4*i +: 4]) > 9 || int'(xb[4*i +: 4]) > 9) ok = 0;
      lim = lim * 10;
    end
    e = !ok;
    s = '0;
    if (ok) begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        va = va * 10 + longint'(xa[4*i +: 4]);
        vb = vb * 10 + longint'(xb[4*i +: 4]);
      end
      tot = va + vb + longint'(c);
      co  = (tot >= lim);
      tot = tot % lim;
      for (int i = 0; i < DIGITS; i++) begin
        s[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      cy = int'(c);
      for (int i = 0; i < DIGITS; i++) begin
        da = int'(xa[4*i +: 4]);
        db = int'(xb[4*i +: 4]);
        t  = da + db + cy;
        if (t > 9) begin
          s[4*i +: 4] = 4'((t + 6) % 16);
          cy = 1;
        end else begin
          s[4*i +: 4] = 4'(t);
          cy = 0;
        end
      end
      co = cy[0];
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Full operation with port scrambling and stray start pulses during ADD/DONE.
  task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic c);
    logic [W-1:0] es;
    logic         ec, ee;
    int           n, nbusy;
    bit           got;
    model(xa, xb, c, es, ec, ee);
    @(negedge clk);
    start = 1'b1; a = xa; b = xb; cin = c;
    @(posedge clk); #1;
    chk({tag, "_acc_busy"}, 64'(busy), 64'd1);
    chk({tag, "_acc_err"},  64'(err),  64'd0);
    chk({tag, "_acc_sum"},  64'(sum),  64'd0);
    n = 0; nbusy = 1; got = 0;
    while (!got && n < DIGITS + 10) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
      else if (busy) nbusy++;
    end
    if (!got) chk({tag, "_timeout"}, 64'(n), 64'(DIGITS));
    else begin
      chk({tag, "_latency"}, 64'(n), 64'(DIGITS));
      chk({tag, "_busycyc"}, 64'(nbusy), 64'(DIGITS));
      chk({tag, "_overlap"}, 64'(busy), 64'd0);
      chk({tag, "_sum"},  64'(sum),  64'(es));
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
      chk({tag, "_err"},  64'(err),  64'(ee));
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk({tag, "_done1cyc"}, 64'(done), 64'd0);
      chk({tag, "_idle"},     64'(busy), 64'd0);
      chk({tag, "_hold"},     64'(sum),  64'(es));
    end
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         ec, ee;
    int           cyc, ndone, first, last;
    bit           gap_ok;

    #1;
    chk("rst_sum",  64'(sum),  64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err",  64'(err),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    do_op("basic",  16'h1234, 16'h5678, 1'b0);
    do_op("wrap",   16'h9999, 16'h0001, 1'b0);
    do_op("allmax", 16'h9999, 16'h9999, 1'b1);
    do_op("inv",    16'h000A, 16'h0000, 1'b0);
    do_op("clrerr", 16'h0001, 16'h0002, 1'b0);
    do_op("invhi",  16'hF000, 16'hF000, 1'b1);

    // Mid-operation asynchronous reset after digit 1 is written.
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_sum", 64'(sum), 64'h0022);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum",  64'(sum),  64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_cout", 64'(cout), 64'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("arst_nodone", 64'(ndone), 64'd0);
    do_op("post_rst", 16'h0005, 16'h0005, 1'b0);

    // Start held high: back-to-back accepts every DIGITS+2 cycles.
    @(negedge clk);
    start = 1'b1; a = 16'h4321; b = 16'h1111; cin = 1'b0;
    model(16'h4321, 16'h1111, 1'b0, es, ec, ee);
    ndone = 0; first = -1; last = -1; gap_ok = 1;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = cyc;
        else if (cyc - last != DIGITS + 2) gap_ok = 0;
        last = cyc;
        ndone++;
        chk("cont_sum", 64'(sum), 64'(es));
      end
    end
    start = 1'b0;
    chk("cont_first", 64'(first), 64'(DIGITS));
    chk("cont_gap",   64'(gap_ok), 64'd1);
    chk("cont_count", 64'(ndone), 64'd5);
    repeat (DIGITS + 3) @(posedge clk);

    for (int k = 0; k < 20; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 3) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 5) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      do_op($sformatf("rnd%0d", k), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Multi-digit packed-BCD adder controller. It time-multiplexes a single 4-bit BCD digit-adder slice across `DIGITS` digit positions, one digit per clock, least significant first. A ripple carry register links consecutive digits. The block sits between a register-mapped or FSM operand source and any consumer of decimal results. It provides a start/busy/done handshake and flags non-BCD input digits.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand. Legal range is 2..16.
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: request a new addition. Sampled only in IDLE.
- `a` input `4*DIGITS`: packed BCD operand A. Digit i is `a[4i+3:4i]`.
- `b` input `4*DIGITS`: packed BCD operand B, same packing as `a`.
- `cin` input 1: carry into digit 0.
- `busy` output 1: high while digits are being processed (ADD state).
- `done` output 1: single-cycle pulse; `sum`/`cout`/`err` are valid while it is high.
- `sum` output `4*DIGITS`: packed BCD result, registered.
- `cout` output 1: decimal carry out of digit `DIGITS-1`, registered.
- `err` output 1: at least one digit of `a` or `b` was greater than 9 in the current operation. Sticky until the next accept.

## Operation
- States:
  - IDLE: waiting for `start`.
  - ADD: processing digit `idx`, where `idx` runs 0..`DIGITS-1`.
  - DONE: one cycle.
- IDLE with `start`=1 at a rising edge (the accept edge):
  - latch `a` and `b` into internal operand registers; the input ports are ignored afterwards;
  - load `carry` from `cin`;
  - set `idx` to 0, and clear `sum`, `cout` and `err`;
  - go to ADD.
- ADD, at each edge:
  - the slice computes `s = A[idx] + B[idx] + carry`, 5 bits wide;
  - if `s > 9`: the digit result is `(s + 6)[3:0]` and the carry becomes 1;
  - otherwise: the digit result is `s[3:0]` and the carry becomes 0;
  - write the digit result into `sum` digit `idx` (in place, not shifted);
  - `err` is set if `A[idx] > 9` or `B[idx] > 9`;
  - `idx` increments.
  - When `idx = DIGITS-1`: also load `cout` with the new carry and go to DONE.
- Invalid (greater than 9) digits still follow the same arithmetic rule, and the output is deterministic. Example: 10+0+0 gives digit 0 with carry 1.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `start` is ignored in DONE.
- `start` in ADD is ignored. No queueing.
- `sum`, `cout` and `err` hold their values in IDLE until the next accept.
- `sum` is not valid while `busy`=1.
- Reset (any time, including mid-ADD):
  - go to IDLE;
  - `sum`=0, `cout`=0, `err`=0, `busy`=0, `done`=0;
  - internal carry, `idx` and operand registers are cleared;
  - no `done` is produced for the aborted operation.

## Timing
- Call the accept edge E0.
  - Digit k is written at edge E(k+1), for k = 0..`DIGITS-1`.
  - `busy`=1 from E0 until E(`DIGITS`).
  - `done`=1 from E(`DIGITS`) until E(`DIGITS`+1).
  - The earliest next accept is E(`DIGITS`+2), with `start` sampled in IDLE.
- Total latency is `DIGITS` cycles from accept to `done`. Throughput is one operation per `DIGITS`+2 cycles.
- `busy` and `done` are decoded from registered state only, with no combinational path from inputs. They are never high together.
- Worst-case per-digit path: the 5-bit add, the compare against 9, and the +6 correction in the slice.

## Structure
- Package `bcd_pkg` holds:
  - the state enum (IDLE, ADD, DONE);
  - `BCD_W`=4, `BCD_MAX`=9, `BCD_CORR`=6.
- Sub-module `bcd_digit_add`:
  - combinational one-digit slice implementing the rule above;
  - inputs: two 4-bit digits and a carry in;
  - outputs: 4-bit digit, carry out, and `invalid` (either input greater than 9).
  - Exactly one instance, muxed by `idx`.
- The controller owns the FSM, `idx` counter (width `$clog2(DIGITS)`), carry register, operand registers and output registers.

## Test plan
- `a`=0x1234, `b`=0x5678, `cin`=0, `DIGITS`=4 -> `sum`=0x6912, `cout`=0, `err`=0. `done` is high exactly 4 edges after accept, for 1 cycle. `busy` is high for 4 cycles.
- `a`=0x9999, `b`=0x0001, `cin`=0 -> `sum`=0x0000, `cout`=1. Then `a`=0x9999, `b`=0x9999, `cin`=1 -> `sum`=0x9999, `cout`=1.
- Pulse `start` during ADD with different operands -> ignored; the first result completes unchanged. `start` held high continuously -> a new accept every 6 cycles, with `done` pulses 6 cycles apart.
- Assert `rst` after digit 1 is written -> all outputs 0 immediately (asynchronous), no `done`. After release, 0x0005+0x0005 -> `sum`=0x0010, `cout`=0.
- `a`=0x000A, `b`=0x0000, `cin`=0 -> `err`=1, `sum`=0x0010, `cout`=0. The next valid operation clears `err` to 0 at accept.
- Change `a` and `b` ports every cycle during ADD -> result reflects only the values latched at accept.
